// File: rtl/axis_packet_gen.sv
// AXI-Stream UDP/IPv4 traffic generator: length sweep, round-robin flows with
// per-flow sequence numbers, token-bucket rate limiting and accepted-traffic counters.
module axis_packet_gen #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int LEN_WIDTH       = 16,
    parameter int FLOW_NUM        = 4,
    parameter int RATE_WIDTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_start,
    input  logic                       cfg_stop,
    input  logic [LEN_WIDTH-1:0]       cfg_len_min,
    input  logic [LEN_WIDTH-1:0]       cfg_len_max,
    input  logic [LEN_WIDTH-1:0]       cfg_len_step,
    input  logic [RATE_WIDTH-1:0]      cfg_rate,
    input  logic [31:0]                cfg_pkt_limit,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                pkt_count,
    output logic [47:0]                byte_count
);

    localparam int KB  = AXIS_KEEP_WIDTH;
    localparam int KBW = $clog2(KB);
    localparam int FW  = (FLOW_NUM > 1) ? $clog2(FLOW_NUM) : 1;
    localparam logic [KBW:0] KB_BYTES = KB[KBW:0];

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DONE} state_t;

    function automatic logic [LEN_WIDTH-1:0] clamp_min_len(input logic [LEN_WIDTH-1:0] len);
        return (len < LEN_WIDTH'(64)) ? LEN_WIDTH'(64) : len;
    endfunction

    // Fixed Ethernet/IPv4/UDP header; byte i sits at tdata[8*i +: 8].
    function automatic logic [AXIS_DATA_WIDTH-1:0] hdr_template();
        logic [AXIS_DATA_WIDTH-1:0] t;
        t = '0;
        t[0*8 +: 8]  = 8'h02;  t[5*8 +: 8]  = 8'h02;   // dst MAC 02:00:00:00:00:02
        t[6*8 +: 8]  = 8'h02;  t[11*8 +: 8] = 8'h01;   // src MAC 02:00:00:00:00:01
        t[12*8 +: 8] = 8'h08;  t[13*8 +: 8] = 8'h00;   // ethertype IPv4
        t[14*8 +: 8] = 8'h45;  t[20*8 +: 8] = 8'h40;   // version/IHL, DF
        t[22*8 +: 8] = 8'h40;  t[23*8 +: 8] = 8'h11;   // TTL 64, UDP
        t[26*8 +: 8] = 8'h0a;  t[29*8 +: 8] = 8'h01;   // src IP 10.0.0.1
        t[30*8 +: 8] = 8'h0a;  t[33*8 +: 8] = 8'h02;   // dst IP 10.0.0.2
        t[34*8 +: 8] = 8'h10;                          // src port high byte
        t[36*8 +: 8] = 8'h12;  t[37*8 +: 8] = 8'h34;   // dst port 0x1234
        return t;
    endfunction

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_min_q, len_min_d, len_max_q, len_max_d;
    logic [LEN_WIDTH-1:0]   len_step_q, len_step_d, cur_len_q, cur_len_d;
    logic [LEN_WIDTH-1:0]   beat_idx_q, beat_idx_d;
    logic [RATE_WIDTH-1:0]  rate_q, rate_d, acc_q, acc_d;
    logic [31:0]            pkt_limit_q, pkt_limit_d, pkt_count_q, pkt_count_d;
    logic [31:0]            pay_cnt_q, pay_cnt_d;
    logic [47:0]            byte_count_q, byte_count_d;
    logic [FW-1:0]          flow_q, flow_d;
    logic [31:0]            seq_q [FLOW_NUM];
    logic [31:0]            seq_d [FLOW_NUM];
    logic                   tok_q, tok_d, held_q, held_d, stop_q, stop_d;

    logic [KBW-1:0]         rem;
    logic [LEN_WIDTH-1:0]   beats;
    logic                   last_beat;
    logic [KBW:0]           beat_bytes;
    logic [KB-1:0]          last_keep;
    logic [LEN_WIDTH:0]     len_sum;
    logic [LEN_WIDTH-1:0]   next_len;
    logic [RATE_WIDTH:0]    acc_sum;
    logic                   tvalid_int, hs, run_end;
    logic [15:0]            ip_len;
    logic [31:0]            cur_seq;
    logic [AXIS_DATA_WIDTH-1:0] hdr_beat, pay_beat;

    assign rem        = cur_len_q[KBW-1:0];
    assign beats      = (cur_len_q >> KBW) + LEN_WIDTH'(rem != '0);
    assign last_beat  = (beat_idx_q == beats - LEN_WIDTH'(1));
    assign beat_bytes = (last_beat && rem != '0) ? {1'b0, rem} : KB_BYTES;
    assign tvalid_int = (state_q == S_HDR || state_q == S_PAYLOAD) && (tok_q || held_q);
    assign hs         = tvalid_int && m_axis_tready;
    assign acc_sum    = {1'b0, acc_q} + {1'b0, rate_q};

    // Sweep wraps back to the minimum on exceeding the ceiling or on add overflow.
    assign len_sum  = {1'b0, cur_len_q} + {1'b0, len_step_q};
    assign next_len = (len_step_q == '0) ? cur_len_q :
                      (len_sum[LEN_WIDTH] || len_sum[LEN_WIDTH-1:0] > len_max_q) ? len_min_q :
                      len_sum[LEN_WIDTH-1:0];
    assign run_end  = stop_q || cfg_stop ||
                      (pkt_limit_q != '0 && pkt_count_q + 32'd1 == pkt_limit_q);

    always_comb begin
        last_keep = '0;
        for (int i = 0; i < KB; i++) begin
            last_keep[i] = (rem == '0) || (KBW'(i) < rem);
        end
    end

    assign ip_len   = 16'(cur_len_q - LEN_WIDTH'(14));
    assign cur_seq  = seq_q[flow_q];
    assign pay_beat = {{(AXIS_DATA_WIDTH-32){1'b0}}, pay_cnt_q};

    always_comb begin
        hdr_beat = hdr_template();
        hdr_beat[16*8 +: 8] = ip_len[15:8];
        hdr_beat[17*8 +: 8] = ip_len[7:0];
        hdr_beat[35*8 +: 8] = 8'(flow_q);
        hdr_beat[42*8 +: 8] = cur_seq[31:24];
        hdr_beat[43*8 +: 8] = cur_seq[23:16];
        hdr_beat[44*8 +: 8] = cur_seq[15:8];
        hdr_beat[45*8 +: 8] = cur_seq[7:0];
    end

    always_comb begin
        state_d      = state_q;
        len_min_d    = len_min_q;
        len_max_d    = len_max_q;
        len_step_d   = len_step_q;
        cur_len_d    = cur_len_q;
        beat_idx_d   = beat_idx_q;
        rate_d       = rate_q;
        acc_d        = acc_q;
        pkt_limit_d  = pkt_limit_q;
        pkt_count_d  = pkt_count_q;
        pay_cnt_d    = pay_cnt_q;
        byte_count_d = byte_count_q;
        flow_d       = flow_q;
        seq_d        = seq_q;
        tok_d        = tok_q;
        stop_d       = stop_q;
        held_d       = tvalid_int && !m_axis_tready;

        // Token bucket: a carry in the same cycle as a handshake keeps the token.
        if (state_q != S_IDLE) begin
            acc_d = acc_sum[RATE_WIDTH-1:0];
            if (rate_q == '0 || acc_sum[RATE_WIDTH]) tok_d = 1'b1;
            else if (hs)                             tok_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    len_min_d    = clamp_min_len(cfg_len_min);
                    cur_len_d    = clamp_min_len(cfg_len_min);
                    len_max_d    = cfg_len_max;
                    len_step_d   = cfg_len_step;
                    rate_d       = cfg_rate;
                    pkt_limit_d  = cfg_pkt_limit;
                    acc_d        = '0;
                    tok_d        = (cfg_rate == '0);
                    flow_d       = '0;
                    for (int i = 0; i < FLOW_NUM; i++) seq_d[i] = '0;
                    pay_cnt_d    = 32'd1;
                    pkt_count_d  = '0;
                    byte_count_d = '0;
                    beat_idx_d   = '0;
                    stop_d       = 1'b0;
                    state_d      = S_HDR;
                end
            end
            S_HDR, S_PAYLOAD: begin
                if (cfg_stop) stop_d = 1'b1;
                if (hs) begin
                    byte_count_d = byte_count_q + 48'(beat_bytes);
                    if (state_q == S_PAYLOAD) pay_cnt_d = pay_cnt_q + 32'd1;
                    if (last_beat) begin
                        pkt_count_d    = pkt_count_q + 32'd1;
                        seq_d[flow_q]  = cur_seq + 32'd1;
                        flow_d         = (flow_q == FW'(FLOW_NUM - 1)) ? '0 : flow_q + FW'(1);
                        cur_len_d      = next_len;
                        beat_idx_d     = '0;
                        state_d        = run_end ? S_DONE : S_HDR;
                    end else begin
                        beat_idx_d = beat_idx_q + LEN_WIDTH'(1);
                        state_d    = S_PAYLOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_min_q    <= '0;
            len_max_q    <= '0;
            len_step_q   <= '0;
            cur_len_q    <= '0;
            beat_idx_q   <= '0;
            rate_q       <= '0;
            acc_q        <= '0;
            pkt_limit_q  <= '0;
            pkt_count_q  <= '0;
            pay_cnt_q    <= '0;
            byte_count_q <= '0;
            flow_q       <= '0;
            for (int i = 0; i < FLOW_NUM; i++) seq_q[i] <= '0;
            tok_q        <= 1'b0;
            held_q       <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_min_q    <= len_min_d;
            len_max_q    <= len_max_d;
            len_step_q   <= len_step_d;
            cur_len_q    <= cur_len_d;
            beat_idx_q   <= beat_idx_d;
            rate_q       <= rate_d;
            acc_q        <= acc_d;
            pkt_limit_q  <= pkt_limit_d;
            pkt_count_q  <= pkt_count_d;
            pay_cnt_q    <= pay_cnt_d;
            byte_count_q <= byte_count_d;
            flow_q       <= flow_d;
            seq_q        <= seq_d;
            tok_q        <= tok_d;
            held_q       <= held_d;
            stop_q       <= stop_d;
        end
    end

    // Outputs are zero whenever no beat is offered, including during reset.
    assign m_axis_tvalid = tvalid_int;
    assign m_axis_tdata  = !tvalid_int ? '0 : (state_q == S_HDR) ? hdr_beat : pay_beat;
    assign m_axis_tkeep  = !tvalid_int ? '0 : last_beat ? last_keep : '1;
    assign m_axis_tlast  = tvalid_int && last_beat;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign pkt_count     = pkt_count_q;
    assign byte_count    = byte_count_q;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Scoreboard bench for axis_packet_gen: expected beats are queued per run and
// popped by an independent monitor on every handshake.
module tb_axis_packet_gen;

    localparam int DW = 512;
    localparam int KW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0, cfg_stop = 1'b0;
    logic [15:0]   cfg_len_min = '0, cfg_len_max = '0, cfg_len_step = '0;
    logic [7:0]    cfg_rate = '0;
    logic [31:0]   cfg_pkt_limit = '0;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid, m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic          busy, done;
    logic [31:0]   pkt_count;
    logic [47:0]   byte_count;

    always #5 clk = ~clk;

    axis_packet_gen dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_len_min(cfg_len_min), .cfg_len_max(cfg_len_max), .cfg_len_step(cfg_len_step),
        .cfg_rate(cfg_rate), .cfg_pkt_limit(cfg_pkt_limit),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done),
        .pkt_count(pkt_count), .byte_count(byte_count)
    );

    typedef struct {
        bit          hdr;
        logic [15:0] iplen;
        logic [7:0]  flow;
        logic [31:0] seq;
        logic [31:0] pay;
        logic [63:0] keep;
        bit          last;
    } exp_t;

    exp_t          q[$];
    int            checks = 0, errors = 0;
    int            cyc = 0, hs_n = 0, done_cnt = 0;
    int            hs_cyc [8192];
    bit            rand_rdy = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [KW-1:0] prev_keep;
    logic          prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_axis_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(m_axis_tvalid), 64'd1);
                check("hold_data_lo", m_axis_tdata[63:0], prev_data[63:0]);
                check("hold_data_all", 64'(m_axis_tdata == prev_data), 64'd1);
                check("hold_keep", m_axis_tkeep, prev_keep);
                check("hold_last", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (hs_n < 8192) hs_cyc[hs_n] = cyc;
                hs_n++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_beat actual=beat required=none");
                end else begin
                    e = q.pop_front();
                    if (e.hdr) begin
                        check("hdr_ethertype", {48'd0, m_axis_tdata[12*8 +: 8], m_axis_tdata[13*8 +: 8]}, 64'h0800);
                        check("hdr_iplen", {48'd0, m_axis_tdata[16*8 +: 8], m_axis_tdata[17*8 +: 8]}, 64'(e.iplen));
                        check("hdr_flow", 64'(m_axis_tdata[35*8 +: 8]), 64'(e.flow));
                        check("hdr_seq", {32'd0, m_axis_tdata[42*8 +: 8], m_axis_tdata[43*8 +: 8],
                                          m_axis_tdata[44*8 +: 8], m_axis_tdata[45*8 +: 8]}, 64'(e.seq));
                    end else begin
                        check("pay_lo", m_axis_tdata[63:0], 64'(e.pay));
                        check("pay_hi_zero", 64'(|m_axis_tdata[DW-1:64]), 64'd0);
                    end
                    check("keep", m_axis_tkeep, e.keep);
                    check("last", 64'(m_axis_tlast), 64'(e.last));
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_keep  = m_axis_tkeep;
            prev_last  = m_axis_tlast;
        end
        if (done) done_cnt++;
    end

    // Reference model of one run: queues every beat of 'npkts' packets.
    task automatic push_run(input int lmin, input int lmax, input int step, input int npkts);
        int unsigned seqs [256];
        int          len, flow, pay, nbeats, rem, nx;
        exp_t        e;
        for (int i = 0; i < 256; i++) seqs[i] = 0;
        len  = (lmin < 64) ? 64 : lmin;
        flow = 0;
        pay  = 1;
        for (int p = 0; p < npkts; p++) begin
            nbeats = (len + 63) / 64;
            rem    = len % 64;
            for (int b = 0; b < nbeats; b++) begin
                e.hdr   = (b == 0);
                e.iplen = 16'(len - 14);
                e.flow  = 8'(flow);
                e.seq   = seqs[flow];
                e.pay   = 32'(pay);
                e.last  = (b == nbeats - 1);
                e.keep  = (e.last && rem != 0) ? ((64'd1 << rem) - 64'd1) : {64{1'b1}};
                if (b != 0) pay++;
                q.push_back(e);
            end
            seqs[flow]++;
            flow = (flow + 1) % 4;
            if (step != 0) begin
                nx = len + step;
                if (nx > lmax || nx > 65535) nx = (lmin < 64) ? 64 : lmin;
                len = nx;
            end
        end
    endtask

    task automatic start(input int lmin, input int lmax, input int step, input int limit, input int rate);
        @(negedge clk);
        cfg_len_min   = 16'(lmin);
        cfg_len_max   = 16'(lmax);
        cfg_len_step  = 16'(step);
        cfg_rate      = 8'(rate);
        cfg_pkt_limit = 32'(limit);
        cfg_start     = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        if (rate == 0) check("tvalid_after_start", 64'(m_axis_tvalid), 64'd1);
        // Scramble config mid-run; it must have been latched at start.
        cfg_len_min  = 16'h0400;
        cfg_len_step = 16'h0001;
        cfg_rate     = 8'h01;
        cfg_pkt_limit = 32'd999;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n <= budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done_within_%0d", budget);
        end
    endtask

    task automatic wait_beats(input int base, input int k, input int budget);
        int n = 0;
        while (hs_n - base < k && n <= budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (hs_n - base < k) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout actual=%0d required=%0d", hs_n - base, k);
        end
    endtask

    task automatic run(input string name, input int lmin, input int lmax, input int step,
                       input int limit, input int rate, input int exp_bytes, output int base);
        int dbase;
        push_run(lmin, lmax, step, limit);
        base  = hs_n;
        dbase = done_cnt;
        start(lmin, lmax, step, limit, rate);
        wait_done(5000);
        check({name, "_pkt_count"}, 64'(pkt_count), 64'(limit));
        check({name, "_byte_count"}, 64'(byte_count), 64'(exp_bytes));
        check({name, "_busy_with_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        #1;
        check({name, "_busy_after"}, 64'(busy), 64'd0);
        check({name, "_done_pulses"}, 64'(done_cnt - dbase), 64'd1);
        check({name, "_all_beats_seen"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        int base, dbase;
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", m_axis_tdata[63:0], 64'd0);
        check("rst_tkeep", m_axis_tkeep, 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_byte_count", 64'(byte_count), 64'd0);
        #30;
        @(negedge clk);
        rst_n = 1'b1;

        run("fixed64", 64, 64, 0, 3, 0, 192, base);
        check("fixed64_back_to_back", 64'(hs_cyc[base + 2] - hs_cyc[base]), 64'd2);

        run("len100", 100, 100, 0, 1, 0, 100, base);
        run("sweep", 64, 192, 64, 5, 0, 576, base);
        run("min_clamp", 10, 10, 0, 1, 0, 64, base);

        rand_rdy = 1'b1;
        run("stall", 64, 300, 70, 20, 0, 3380, base);
        rand_rdy = 1'b0;

        run("rate128", 1024, 1024, 0, 2, 128, 2048, base);
        check_range("rate128_span", hs_cyc[base + 31] - hs_cyc[base], 60, 64);
        run("rate64", 1024, 1024, 0, 2, 64, 2048, base);
        check_range("rate64_span", hs_cyc[base + 31] - hs_cyc[base], 122, 126);

        run("len_overflow", 65000, 65535, 600, 2, 0, 130000, base);

        // Stop during beat 5 of a 16-beat packet in an unlimited run.
        push_run(1024, 1024, 0, 1);
        base  = hs_n;
        dbase = done_cnt;
        start(1024, 1024, 0, 0, 0);
        wait_beats(base, 5, 100);
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        wait_done(200);
        check("stop_pkt_count", 64'(pkt_count), 64'd1);
        check("stop_byte_count", 64'(byte_count), 64'd1024);
        @(negedge clk);
        #1;
        check("stop_done_pulses", 64'(done_cnt - dbase), 64'd1);
        check("stop_all_beats_seen", 64'(q.size()), 64'd0);
        repeat (5) @(negedge clk);
        check("stop_stays_idle", 64'(busy), 64'd0);

        // Asynchronous reset mid-packet.
        push_run(1024, 1024, 0, 1);
        base = hs_n;
        start(1024, 1024, 0, 0, 0);
        wait_beats(base, 3, 100);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("arst_tdata", 64'(|m_axis_tdata), 64'd0);
        check("arst_tkeep", m_axis_tkeep, 64'd0);
        check("arst_tlast", 64'(m_axis_tlast), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_byte_count", 64'(byte_count), 64'd0);
        check("arst_pkt_count", 64'(pkt_count), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
